bn_param_loader: RTL and testbench
==================================

# bn_param_loader

Writer side of the batch-normalization parameter path. Receives per-neuron BN configuration frames over a 4-bit valid/ready stream and validates each frame against the constraints of the BN datapath. Stores accepted values in a double-buffered register bank. Serves the active `BN_factor`/`BN_addend` pair for any neuron to the `batch_normalization` datapath. Sits between the chip's configuration input pins and the neuron array; updates take effect only on a time-step boundary.

## Interface
Parameters:
- `NEURONS`, default 4: number of neurons with their own BN parameter pair. Range 1..16.
- `ADDEND_WIDTH`, default 4: width of the signed addend, equal to `WIDTH-2` of the datapath. Range 1..4.
- `ADDR_WIDTH`, default `$clog2(NEURONS)` (minimum 1): width of the read address.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `cfg_valid`, in, 1: the nibble on `cfg_data` is valid.
- `cfg_data`, in, 4: configuration nibble.
- `cfg_ready`, out, 1: loader accepts a nibble this cycle.
- `apply`, in, 1: time-step boundary strobe; copies the shadow bank to the active bank.
- `cfg_done`, out, 1: one-cycle pulse when a frame has been written to the shadow bank.
- `cfg_error`, out, 1: one-cycle pulse when a frame is rejected.
- `err_code`, out, 2: reason for the last rejection; held until the next rejection.
- `rd_addr`, in, `ADDR_WIDTH`: neuron index to read.
- `rd_factor`, out, 4: active `BN_factor` for `rd_addr`.
- `rd_addend`, out, `ADDEND_WIDTH`: active `BN_addend` for `rd_addr`, signed.

## Operation
- Frame = 3 nibbles, in order: address, factor code, addend.
- A nibble transfers on a rising edge with `cfg_valid & cfg_ready`.
- Addend is taken from `cfg_data[ADDEND_WIDTH-1:0]`; higher bits are ignored.
- FSM states: `S_ADDR` → `S_FACTOR` → `S_ADDEND` → `S_CHECK` → `S_ADDR`.
  - Each of the first three states advances on a transfer.
  - `S_CHECK` lasts exactly 1 cycle with `cfg_ready=0`.
  - `cfg_ready` = 1 in `S_ADDR`, `S_FACTOR` and `S_ADDEND`.
- Validation in `S_CHECK`, first match wins:
  - err 1: address ≥ `NEURONS`.
  - err 2: factor ∈ {0000, 0111, 1011, 1111} (zero or a multiplier above 8).
  - err 3: factor = 0011 (×8) with a nonzero addend.
- Valid frame: write factor and addend to `shadow[addr]`; pulse `cfg_done` on the cycle after `S_CHECK`.
- Invalid frame: no write; pulse `cfg_error`; update `err_code`.
- `apply` high on an edge: `active[i] <= shadow[i]` for all i.
- `apply` on the same edge as a shadow write: active receives the pre-write shadow value. The new value reaches active on the next `apply`.
- Read path is combinational from the active bank. `rd_addr` ≥ `NEURONS` returns factor 0100 and addend 0.
- Reset values:
  - FSM in `S_ADDR`, so `cfg_ready=1` immediately after reset.
  - `cfg_done=0`, `cfg_error=0`, `err_code=0`.
  - All shadow and active entries = factor 0100 (×1), addend 0.
- Reset asserted mid-frame discards the partial frame. After release the next nibble is treated as an address.

## Timing
- Frame latency: last nibble transfer at edge N → `S_CHECK` during cycle N+1 → shadow write and `cfg_done`/`cfg_error` visible after edge N+2.
- The next frame's address nibble is accepted no earlier than edge N+2.
- Back-to-back frames run at 4 cycles per frame when `cfg_valid` is held high.
- `apply` to active-bank visibility on `rd_*`: visible after the same edge.
- `cfg_valid` may drop between nibbles indefinitely. There is no timeout; the FSM waits in its current state.
- `cfg_data` is sampled only on transfer edges.

## Structure
- Shared package `bn_pkg` holds:
  - factor code constants (`BN_X1=4'b0100`, `BN_X8=4'b0011`, and the others);
  - the invalid-code list as a function `bn_factor_valid(code)`;
  - the `err_code` enumeration;
  - the FSM state enumeration.
- One sub-module, `bn_param_bank`: a 2×`NEURONS` register bank with write port, `apply` copy and combinational read.
- `bn_param_loader` contains the FSM, nibble capture registers and validation.

## Test plan
- Post-reset read → all `rd_addr` 0..3 return factor 0100 and addend 0; `cfg_ready=1`.
- Frame {1, 0110, 4'b1110} then `apply` → `cfg_done` pulse 2 cycles after the last nibble; `rd_addr=1` reads factor 0110 and addend −2; other entries unchanged.
- Frame {2, 0011, 0001} → `cfg_error` with `err_code=3`, no write. Then frame {2, 0011, 0000} → accepted.
- Frame {5, 0100, 0} with `NEURONS=4` → `err_code=1`. Then frame {0, 1111, 0} → `err_code=2`. `cfg_done` never pulses.
- Write to addr 3 with `apply` asserted on the write edge → active[3] still 0100/0 afterwards; becomes the new value after the second `apply`.
- `rst_n` low after two nibbles of a frame, then frame {0, 1000, 0001} + `apply` → addr 0 reads 1000/1; no stale nibbles consumed.

Source files
------------

// File: rtl/bn_pkg.sv
// rtl/bn_pkg.sv - factor codes, error and state enumerations for the BN parameter path
package bn_pkg;

    localparam logic [3:0] BN_ZERO  = 4'b0000;
    localparam logic [3:0] BN_X1    = 4'b0100;
    localparam logic [3:0] BN_X8    = 4'b0011;
    localparam logic [3:0] BN_OVR_A = 4'b0111;
    localparam logic [3:0] BN_OVR_B = 4'b1011;
    localparam logic [3:0] BN_OVR_C = 4'b1111;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_ADDR   = 2'd1,
        ERR_FACTOR = 2'd2,
        ERR_ADDEND = 2'd3
    } bn_err_e;

    typedef enum logic [1:0] {
        S_ADDR   = 2'd0,
        S_FACTOR = 2'd1,
        S_ADDEND = 2'd2,
        S_CHECK  = 2'd3
    } bn_state_e;

    // Zero and the multipliers above x8 cannot be represented by the datapath.
    function automatic logic bn_factor_valid(input logic [3:0] code);
        return !(code inside {BN_ZERO, BN_OVR_A, BN_OVR_B, BN_OVR_C});
    endfunction

endpackage

// File: rtl/bn_param_bank.sv
// rtl/bn_param_bank.sv - double-buffered shadow/active BN parameter bank
module bn_param_bank
    import bn_pkg::*;
#(
    parameter int NEURONS      = 4,
    parameter int ADDEND_WIDTH = 4,
    parameter int ADDR_WIDTH   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [3:0]              wr_factor,
    input  logic [ADDEND_WIDTH-1:0] wr_addend,
    input  logic                    apply,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [3:0]              rd_factor,
    output logic [ADDEND_WIDTH-1:0] rd_addend
);

    logic [3:0]              shadow_factor [NEURONS];
    logic [ADDEND_WIDTH-1:0] shadow_addend [NEURONS];
    logic [3:0]              active_factor [NEURONS];
    logic [ADDEND_WIDTH-1:0] active_addend [NEURONS];

    // apply copies the shadow value from before this edge's write, so a
    // write landing on an apply edge waits for the following apply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NEURONS; i++) begin
                shadow_factor[i] <= BN_X1;
                shadow_addend[i] <= '0;
                active_factor[i] <= BN_X1;
                active_addend[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NEURONS; i++) begin
                if (wr_en && wr_addr == ADDR_WIDTH'(i)) begin
                    shadow_factor[i] <= wr_factor;
                    shadow_addend[i] <= wr_addend;
                end
                if (apply) begin
                    active_factor[i] <= shadow_factor[i];
                    active_addend[i] <= shadow_addend[i];
                end
            end
        end
    end

    always_comb begin
        rd_factor = BN_X1;
        rd_addend = '0;
        for (int i = 0; i < NEURONS; i++) begin
            if (rd_addr == ADDR_WIDTH'(i)) begin
                rd_factor = active_factor[i];
                rd_addend = active_addend[i];
            end
        end
    end

endmodule

// File: rtl/bn_param_loader.sv
// rtl/bn_param_loader.sv - nibble-stream BN frame loader with validation and bank
module bn_param_loader
    import bn_pkg::*;
#(
    parameter int NEURONS      = 4,
    parameter int ADDEND_WIDTH = 4,
    parameter int ADDR_WIDTH   = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    input  logic [3:0]              cfg_data,
    output logic                    cfg_ready,
    input  logic                    apply,
    output logic                    cfg_done,
    output logic                    cfg_error,
    output logic [1:0]              err_code,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [3:0]              rd_factor,
    output logic [ADDEND_WIDTH-1:0] rd_addend
);

    bn_state_e               state;
    logic [3:0]              addr_q;
    logic [3:0]              factor_q;
    logic [ADDEND_WIDTH-1:0] addend_q;
    logic                    chk_ok;
    logic                    chk_err;
    bn_err_e                 chk_code;
    bn_err_e                 err_q;
    bn_err_e                 verdict;
    logic                    xfer;

    assign cfg_ready = (state != S_CHECK);
    assign xfer      = cfg_valid && cfg_ready;
    assign err_code  = err_q;

    always_comb begin
        verdict = ERR_NONE;
        if (int'(addr_q) >= NEURONS)
            verdict = ERR_ADDR;
        else if (!bn_factor_valid(factor_q))
            verdict = ERR_FACTOR;
        else if (factor_q == BN_X8 && addend_q != '0)
            verdict = ERR_ADDEND;
    end

    // The verdict is latched on leaving S_CHECK and acted on one edge later;
    // addr_q may already hold the next frame's address by then, but the bank
    // samples it before that edge updates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_ADDR;
            addr_q    <= '0;
            factor_q  <= '0;
            addend_q  <= '0;
            chk_ok    <= 1'b0;
            chk_err   <= 1'b0;
            chk_code  <= ERR_NONE;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            err_q     <= ERR_NONE;
        end else begin
            cfg_done  <= chk_ok;
            cfg_error <= chk_err;
            if (chk_err)
                err_q <= chk_code;
            chk_ok  <= 1'b0;
            chk_err <= 1'b0;
            case (state)
                S_ADDR: if (xfer) begin
                    addr_q <= cfg_data;
                    state  <= S_FACTOR;
                end
                S_FACTOR: if (xfer) begin
                    factor_q <= cfg_data;
                    state    <= S_ADDEND;
                end
                S_ADDEND: if (xfer) begin
                    addend_q <= cfg_data[ADDEND_WIDTH-1:0];
                    state    <= S_CHECK;
                end
                S_CHECK: begin
                    chk_ok   <= (verdict == ERR_NONE);
                    chk_err  <= (verdict != ERR_NONE);
                    chk_code <= verdict;
                    state    <= S_ADDR;
                end
                default: state <= S_ADDR;
            endcase
        end
    end

    bn_param_bank #(
        .NEURONS      (NEURONS),
        .ADDEND_WIDTH (ADDEND_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (chk_ok),
        .wr_addr   (ADDR_WIDTH'(addr_q)),
        .wr_factor (factor_q),
        .wr_addend (addend_q),
        .apply     (apply),
        .rd_addr   (rd_addr),
        .rd_factor (rd_factor),
        .rd_addend (rd_addend)
    );

endmodule

// File: tb/tb_bn_param_loader.sv
// tb/tb_bn_param_loader.sv - self-checking bench for bn_param_loader
module tb_bn_param_loader;

    localparam int N   = 4;
    localparam int AW  = 4;
    localparam int RAW = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cfg_valid = 1'b0;
    logic [3:0]     cfg_data = 4'd0;
    logic           cfg_ready;
    logic           apply = 1'b0;
    logic           cfg_done;
    logic           cfg_error;
    logic [1:0]     err_code;
    logic [RAW-1:0] rd_addr = '0;
    logic [3:0]     rd_factor;
    logic [AW-1:0]  rd_addend;

    int checks = 0;
    int failures = 0;

    logic [3:0] m_sf [N];
    logic [3:0] m_sa [N];
    logic [3:0] m_af [N];
    logic [3:0] m_aa [N];
    logic [1:0] m_code;

    typedef struct {
        logic [3:0] a;
        logic [3:0] f;
        logic [3:0] d;
        bit         apl;
        bit         apply_after;
        bit         done;
        bit         err;
        logic [1:0] code;
    } vec_t;

    vec_t tbl [11];

    always #10 clk = ~clk;

    bn_param_loader #(.NEURONS(N), .ADDEND_WIDTH(AW), .ADDR_WIDTH(RAW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .apply(apply), .cfg_done(cfg_done),
        .cfg_error(cfg_error), .err_code(err_code), .rd_addr(rd_addr),
        .rd_factor(rd_factor), .rd_addend(rd_addend)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int model_err(input logic [3:0] a, input logic [3:0] f, input logic [3:0] d);
        if (a >= N) return 1;
        if (f == 4'd0 || f == 4'd7 || f == 4'd11 || f == 4'd15) return 2;
        if (f == 4'd3 && d != 4'd0) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sf[i] = 4'b0100; m_sa[i] = 4'd0;
            m_af[i] = 4'b0100; m_aa[i] = 4'd0;
        end
        m_code = 2'd0;
    endtask

    task automatic model_apply();
        for (int i = 0; i < N; i++) begin
            m_af[i] = m_sf[i];
            m_aa[i] = m_sa[i];
        end
    endtask

    task automatic read_check();
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rd_addr = RAW'(i);
            #1;
            chk($sformatf("rd_factor[%0d]", i), rd_factor, (i < N) ? m_af[i] : 4'b0100);
            chk($sformatf("rd_addend[%0d]", i), rd_addend, (i < N) ? m_aa[i] : 4'd0);
        end
    endtask

    task automatic do_apply();
        @(negedge clk);
        apply = 1'b1;
        @(posedge clk);
        #1 apply = 1'b0;
        model_apply();
    endtask

    task automatic send_nib(input logic [3:0] d, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            cfg_data  = 4'($urandom);
        end
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_data  = d;
        n = 0;
        while (!cfg_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        cfg_data  = 4'($urandom);
    endtask

    task automatic run_frame(input logic [3:0] a, input logic [3:0] f, input logic [3:0] d,
                             input bit apl, input bit e_done, input bit e_err,
                             input logic [1:0] e_code, input int gap);
        int me;
        send_nib(a, gap);
        send_nib(f, gap);
        send_nib(d, gap);
        @(negedge clk);
        chk("check_ready_low", cfg_ready, 0);
        chk("no_early_result", {cfg_done, cfg_error}, 0);
        @(negedge clk);
        chk("ready_back", cfg_ready, 1);
        chk("no_early_result2", {cfg_done, cfg_error}, 0);
        if (apl) apply = 1'b1;
        @(posedge clk);
        #1 apply = 1'b0;
        @(negedge clk);
        chk("cfg_done", cfg_done, e_done);
        chk("cfg_error", cfg_error, e_err);
        chk("err_code", err_code, e_code);
        if (apl) model_apply();
        me = model_err(a, f, d);
        if (me == 0) begin
            m_sf[a[1:0]] = f;
            m_sa[a[1:0]] = d;
        end else begin
            m_code = 2'(me);
        end
        @(negedge clk);
        chk("pulse_one_cycle", {cfg_done, cfg_error}, 0);
    endtask

    task automatic back_to_back();
        logic [3:0] nibs [6];
        int idx, cyc, dones;
        logic rdy;
        nibs[0] = 4'd1; nibs[1] = 4'b0101; nibs[2] = 4'b0011;
        nibs[3] = 4'd2; nibs[4] = 4'b1001; nibs[5] = 4'b1101;
        idx = 0; cyc = 0; dones = 0;
        while (idx < 6 && cyc < 30) begin
            @(negedge clk);
            if (cfg_done) dones++;
            cfg_valid = 1'b1;
            cfg_data  = nibs[idx];
            rdy = cfg_ready;
            @(posedge clk);
            if (rdy) idx++;
            cyc++;
        end
        #1 cfg_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (cfg_done) dones++;
        end
        chk("b2b_cycles", cyc, 7);
        chk("b2b_dones", dones, 2);
        m_sf[1] = 4'b0101; m_sa[1] = 4'b0011;
        m_sf[2] = 4'b1001; m_sa[2] = 4'b1101;
    endtask

    initial begin
        int me;
        logic [3:0] ra, rf, rd;
        bit rapl;

        tbl[0]  = '{4'd1, 4'b0110, 4'b1110, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
        tbl[1]  = '{4'd2, 4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3};
        tbl[2]  = '{4'd2, 4'b0011, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3};
        tbl[3]  = '{4'd5, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[4]  = '{4'd0, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
        tbl[5]  = '{4'd3, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
        tbl[6]  = '{4'd4, 4'b0011, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[7]  = '{4'd8, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[8]  = '{4'd3, 4'b0010, 4'b1010, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1};
        tbl[9]  = '{4'd0, 4'b1011, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
        tbl[10] = '{4'd0, 4'b0011, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3};

        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", cfg_ready, 1);
        chk("reset_done", cfg_done, 0);
        chk("reset_error", cfg_error, 0);
        chk("reset_err_code", err_code, 0);
        read_check();

        for (int i = 0; i < 11; i++) begin
            run_frame(tbl[i].a, tbl[i].f, tbl[i].d, tbl[i].apl,
                      tbl[i].done, tbl[i].err, tbl[i].code, 0);
            if (tbl[i].apply_after) do_apply();
            read_check();
            if (tbl[i].apl) begin
                rd_addr = 3'd3;
                #1;
                chk("same_edge_apply_f", rd_factor, 4'b0100);
                chk("same_edge_apply_a", rd_addend, 4'd0);
                do_apply();
                @(negedge clk);
                rd_addr = 3'd3;
                #1;
                chk("second_apply_f", rd_factor, 4'b0010);
                chk("second_apply_a", rd_addend, 4'b1010);
            end
        end

        back_to_back();
        do_apply();
        read_check();

        for (int k = 0; k < 40; k++) begin
            ra = 4'($urandom_range(0, 5));
            rf = 4'($urandom);
            rd = 4'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                rf = 4'b0011;
                rd = ($urandom_range(0, 1) == 0) ? 4'd0 : rd;
            end
            rapl = ($urandom_range(0, 3) == 0);
            me = model_err(ra, rf, rd);
            run_frame(ra, rf, rd, rapl, me == 0, me != 0,
                      (me != 0) ? 2'(me) : m_code, $urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) do_apply();
            read_check();
        end

        send_nib(4'd1, 0);
        send_nib(4'b0110, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("midreset_ready", cfg_ready, 1);
        chk("midreset_err_code", err_code, 0);
        run_frame(4'd0, 4'b1000, 4'b0001, 1'b0, 1'b1, 1'b0, 2'd0, 0);
        do_apply();
        @(negedge clk);
        rd_addr = 3'd0;
        #1;
        chk("midreset_f", rd_factor, 4'b1000);
        chk("midreset_a", rd_addend, 4'b0001);
        read_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
